// File: rtl/serial_alu_seq_if.sv
// Request/response bundle for the nibble-serial ALU: operand/opcode request in,
// registered result plus flags out, each on its own valid/ready handshake.
interface serial_alu_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero
  );
endinterface

// File: rtl/serial_alu_seq.sv
// Wide-word ALU that walks a 4-bit datapath across the operands, LSB nibble
// first, rippling carry between nibbles through a registered carry flop.
module serial_alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  serial_alu_seq_if.slave bus
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cout_q;
  logic             overflow_q;
  logic             zero_q;

  logic [3:0]       a_nib;
  logic [3:0]       b_eff;
  logic [3:0]       res_nib;
  logic [4:0]       sum5;
  logic             is_arith;
  logic             ovf_raw;
  logic             last_nib;
  logic             carry_d;
  logic [WIDTH-1:0] shadow_d;
  logic [WIDTH-1:0] result_d;
  logic             cout_d;
  logic             overflow_d;
  logic             zero_d;

  // One nibble step; operand registers shift right so the active nibble is always [3:0].
  always_comb begin
    a_nib    = a_q[3:0];
    b_eff    = b_q[3:0] ^ {4{op_q[2]}};
    sum5     = {1'b0, a_nib} + {1'b0, b_eff} + 5'(carry_q);
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    res_nib  = 4'h0;
    case (op_q)
      OP_AND:                 res_nib = a_nib & b_q[3:0];
      OP_OR:                  res_nib = a_nib | b_q[3:0];
      OP_ADD, OP_SUB, OP_SLT: res_nib = sum5[3:0];
      default:                res_nib = 4'h0;
    endcase
    carry_d  = is_arith ? sum5[4] : carry_q;
    shadow_d = {res_nib, shadow_q[WIDTH-1:4]};
    ovf_raw  = (a_nib[3] == b_eff[3]) && (sum5[3] != a_nib[3]);
    last_nib = (cnt_q == CNT_W'(NIBBLES - 1));
  end

  // Final result and flags, only meaningful while the last nibble is in flight.
  always_comb begin
    result_d   = shadow_d;
    cout_d     = 1'b0;
    overflow_d = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        cout_d     = sum5[4];
        overflow_d = ovf_raw;
      end
      OP_SLT: begin
        result_d = WIDTH'(sum5[3] ^ ovf_raw);
        cout_d   = sum5[4];
      end
      OP_AND, OP_OR: result_d = shadow_d;
      default:       result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  // Control FSM; visible outputs only move on the DONE entry edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 3'b000;
      shadow_q    <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            op_q       <= bus.in_op;
            carry_q    <= bus.in_op[2];
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          a_q      <= a_q >> 4;
          b_q      <= b_q >> 4;
          shadow_q <= shadow_d;
          carry_q  <= carry_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_nib) begin
            result_q    <= result_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq: per-op vectors, latency, backpressure and mid-op reset.
module tb_serial_alu_seq;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  serial_alu_seq_if #(.WIDTH(16)) bus ();

  serial_alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        co;
    logic        ov;
    logic        z;
  } vec_t;

  // Issue one request, wait (bounded) for the response and take it.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic co, output logic ov,
                       output logic z, output int lat);
    int guard;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait in_ready=%b expected 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout out_valid=%b expected 1", bus.out_valid);
    end
    res = bus.result;
    co  = bus.cout;
    ov  = bus.overflow;
    z   = bus.zero;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.result !== 16'h0000 || bus.cout !== 1'b0 || bus.overflow !== 1'b0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_out result=%h c=%b v=%b z=%b expected 0000 0 0 0",
               bus.result, bus.cout, bus.overflow, bus.zero);
    end
  endtask

  task automatic test_ops();
    vec_t        v [9];
    logic [15:0] res;
    logic        co, ov, z;
    int          lat;
    v[0] = '{"add_7fff_1",  3'b010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
    v[1] = '{"add_ffff_1",  3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
    v[2] = '{"sub_5_7",     3'b110, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    v[3] = '{"sub_8000_1",  3'b110, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    v[4] = '{"slt_8000_1",  3'b111, 16'h8000, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0};
    v[5] = '{"slt_3_3",     3'b111, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1};
    v[6] = '{"and",         3'b000, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
    v[7] = '{"or",          3'b001, 16'hF0F0, 16'h3C3C, 16'hFCFC, 1'b0, 1'b0, 1'b0};
    v[8] = '{"reserved011", 3'b011, 16'hF0F0, 16'h3C3C, 16'h0000, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, res, co, ov, z, lat);
      checks++;
      if (res !== v[i].res) begin
        errors++;
        $display("FAIL %s result got %h expected %h", v[i].name, res, v[i].res);
      end
      checks++;
      if ({co, ov, z} !== {v[i].co, v[i].ov, v[i].z}) begin
        errors++;
        $display("FAIL %s flags c/v/z got %b%b%b expected %b%b%b",
                 v[i].name, co, ov, z, v[i].co, v[i].ov, v[i].z);
      end
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL %s latency got %0d expected 5", v[i].name, lat);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s post_handshake out_valid=%b in_ready=%b expected 0 1",
                 v[i].name, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h1234;
    bus.in_b     = 16'h1111;
    bus.in_op    = 3'b010;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    guard = 0;
    while (bus.out_valid !== 1'b1 && guard < 30) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 16'h2345) begin
      errors++;
      $display("FAIL bp_first out_valid=%b result=%h expected 1 2345", bus.out_valid, bus.result);
    end
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0001;
    bus.in_b     = 16'h0001;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.result !== 16'h2345 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d result=%h in_ready=%b out_valid=%b expected 2345 0 1",
                 c, bus.result, bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_no_second cycle %0d out_valid=%b in_ready=%b expected 0 1",
                 c, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] res;
    logic        co, ov, z;
    int          lat;
    logic        seen_valid;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h00FF;
    bus.in_b     = 16'h0001;
    bus.in_op    = 3'b010;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_async in_ready=%b out_valid=%b result=%h expected 1 0 0000",
               bus.in_ready, bus.out_valid, bus.result);
    end
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_quiet seen_valid=%b in_ready=%b expected 0 1", seen_valid, bus.in_ready);
    end
    do_op(3'b010, 16'h0001, 16'h0002, res, co, ov, z, lat);
    checks++;
    if (res !== 16'h0003 || {co, ov, z} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_add result=%h cvz=%b%b%b expected 0003 000", res, co, ov, z);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = 3'b000;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_ops();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
